// File: rtl/vga_pixel_fifo_out_if.sv
// Pixel FIFO bundle: upstream write port, occupancy status, and the timing-generator/DAC side.
// master drives requests and syncs; slave is the FIFO.
interface vga_pixel_fifo_out_if #(
    parameter int P_DEPTH_N = 6
);
    logic                 iFLUSH;
    logic                 iWR_REQ;
    logic [23:0]          iWR_DATA;
    logic                 oWR_FULL;
    logic                 oWR_ALMOST_FULL;
    logic [P_DEPTH_N:0]   oCOUNT;
    logic                 iDATA_REQ;
    logic                 iDISP_VSYNC;
    logic                 iDISP_HSYNC;
    logic                 iDISP_BLANK;
    logic [7:0]           oDISP_R;
    logic [7:0]           oDISP_G;
    logic [7:0]           oDISP_B;
    logic                 oDISP_VSYNC;
    logic                 oDISP_HSYNC;
    logic                 oDISP_BLANK;
    logic                 oUNDERFLOW;

    modport master (
        output iFLUSH, iWR_REQ, iWR_DATA, iDATA_REQ, iDISP_VSYNC, iDISP_HSYNC, iDISP_BLANK,
        input  oWR_FULL, oWR_ALMOST_FULL, oCOUNT, oDISP_R, oDISP_G, oDISP_B,
               oDISP_VSYNC, oDISP_HSYNC, oDISP_BLANK, oUNDERFLOW
    );

    modport slave (
        input  iFLUSH, iWR_REQ, iWR_DATA, iDATA_REQ, iDISP_VSYNC, iDISP_HSYNC, iDISP_BLANK,
        output oWR_FULL, oWR_ALMOST_FULL, oCOUNT, oDISP_R, oDISP_G, oDISP_B,
               oDISP_VSYNC, oDISP_HSYNC, oDISP_BLANK, oUNDERFLOW
    );
endinterface

// File: rtl/vga_pixel_fifo_out.sv
// Single-clock pixel FIFO in front of the video DAC; RGB is read out with one cycle of latency
// and the timing syncs/blank are delayed by one register so they stay aligned with it.
module vga_pixel_fifo_out #(
    parameter int P_DEPTH   = 64,
    parameter int P_DEPTH_N = 6,
    parameter int P_AFULL   = 56
) (
    input  logic                   iVGA_CLOCK,
    input  logic                   iRESET_SYNC,
    vga_pixel_fifo_out_if.slave    bus
);
    localparam logic [P_DEPTH_N:0]   LP_DEPTH   = (P_DEPTH_N + 1)'(P_DEPTH);
    localparam logic [P_DEPTH_N:0]   LP_AFULL   = (P_DEPTH_N + 1)'(P_AFULL);
    localparam logic [P_DEPTH_N:0]   LP_CNT_ONE = (P_DEPTH_N + 1)'(1);
    localparam logic [P_DEPTH_N-1:0] LP_PTR_ONE = P_DEPTH_N'(1);

    logic [23:0]          r_mem [P_DEPTH];
    logic [P_DEPTH_N-1:0] r_wr_ptr;
    logic [P_DEPTH_N-1:0] r_rd_ptr;
    logic [P_DEPTH_N:0]   r_count;
    logic [23:0]          r_rgb;
    logic                 r_vsync;
    logic                 r_hsync;
    logic                 r_blank;
    logic                 r_underflow;

    logic w_wr_ok;
    logic w_rd_ok;
    logic w_mem_we;

    // Acceptance uses the pre-cycle count, so a pop never frees room for a same-cycle write.
    assign w_wr_ok  = bus.iWR_REQ && (r_count != LP_DEPTH);
    assign w_rd_ok  = bus.iDATA_REQ && (r_count != '0);
    assign w_mem_we = w_wr_ok && !iRESET_SYNC && !bus.iFLUSH;

    always_ff @(posedge iVGA_CLOCK) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr] <= bus.iWR_DATA;
        end
    end

    always_ff @(posedge iVGA_CLOCK) begin
        if (iRESET_SYNC) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rgb       <= '0;
            r_underflow <= 1'b0;
        end else if (bus.iFLUSH) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rgb       <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
                r_rgb    <= r_mem[r_rd_ptr];
            end else begin
                r_rgb    <= '0;
            end
            if (bus.iDATA_REQ && (r_count == '0)) begin
                r_underflow <= 1'b1;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + LP_CNT_ONE;
                2'b01:   r_count <= r_count - LP_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sync/blank keep flowing through flush; only reset parks them inactive-high.
    always_ff @(posedge iVGA_CLOCK) begin
        if (iRESET_SYNC) begin
            r_vsync <= 1'b1;
            r_hsync <= 1'b1;
            r_blank <= 1'b1;
        end else begin
            r_vsync <= bus.iDISP_VSYNC;
            r_hsync <= bus.iDISP_HSYNC;
            r_blank <= bus.iDISP_BLANK;
        end
    end

    assign bus.oWR_FULL        = (r_count == LP_DEPTH);
    assign bus.oWR_ALMOST_FULL = (r_count >= LP_AFULL);
    assign bus.oCOUNT          = r_count;
    assign bus.oDISP_R         = r_rgb[23:16];
    assign bus.oDISP_G         = r_rgb[15:8];
    assign bus.oDISP_B         = r_rgb[7:0];
    assign bus.oDISP_VSYNC     = r_vsync;
    assign bus.oDISP_HSYNC     = r_hsync;
    assign bus.oDISP_BLANK     = r_blank;
    assign bus.oUNDERFLOW      = r_underflow;
endmodule

// File: tb/tb_vga_pixel_fifo_out.sv
// Bench for vga_pixel_fifo_out: directed scenarios plus random traffic, all checked
// every cycle against a queue-based reference model.
module tb_vga_pixel_fifo_out;
    localparam int DEPTH = 64;
    localparam int DN    = 6;
    localparam int AF    = 56;

    logic clk_sys = 1'b0;
    logic rst     = 1'b1;
    always #5 clk_sys = ~clk_sys;

    vga_pixel_fifo_out_if #(.P_DEPTH_N(DN)) bus ();

    vga_pixel_fifo_out #(
        .P_DEPTH   (DEPTH),
        .P_DEPTH_N (DN),
        .P_AFULL   (AF)
    ) dut (
        .iVGA_CLOCK  (clk_sys),
        .iRESET_SYNC (rst),
        .bus         (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] m_q[$];
    logic [23:0] m_rgb;
    logic        m_uf;
    logic        m_vs, m_hs, m_bl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, clock, then compare every output.
    task automatic cycle(input logic r, input logic f, input logic w, input logic [23:0] d,
                         input logic req, input logic vs, input logic hs, input logic bl);
        int n;
        rst             = r;
        bus.iFLUSH      = f;
        bus.iWR_REQ     = w;
        bus.iWR_DATA    = d;
        bus.iDATA_REQ   = req;
        bus.iDISP_VSYNC = vs;
        bus.iDISP_HSYNC = hs;
        bus.iDISP_BLANK = bl;
        n = m_q.size();
        if (r) begin
            m_q.delete();
            m_rgb = '0; m_uf = 1'b0;
            m_vs = 1'b1; m_hs = 1'b1; m_bl = 1'b1;
        end else begin
            m_vs = vs; m_hs = hs; m_bl = bl;
            if (f) begin
                m_q.delete();
                m_rgb = '0; m_uf = 1'b0;
            end else begin
                if (req && n > 0) m_rgb = m_q.pop_front();
                else              m_rgb = '0;
                if (req && n == 0) m_uf = 1'b1;
                if (w && n < DEPTH) m_q.push_back(d);
            end
        end
        @(posedge clk_sys);
        #1;
        check("rgb",    {bus.oDISP_R, bus.oDISP_G, bus.oDISP_B}, m_rgb);
        check("count",  bus.oCOUNT, m_q.size());
        check("full",   bus.oWR_FULL, m_q.size() == DEPTH);
        check("afull",  bus.oWR_ALMOST_FULL, m_q.size() >= AF);
        check("uflow",  bus.oUNDERFLOW, m_uf);
        check("vsync",  bus.oDISP_VSYNC, m_vs);
        check("hsync",  bus.oDISP_HSYNC, m_hs);
        check("blank",  bus.oDISP_BLANK, m_bl);
    endtask

    task automatic op(input logic w, input logic [23:0] d, input logic req);
        cycle(1'b0, 1'b0, w, d, req, 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        m_rgb = '0; m_uf = 1'b0; m_vs = 1'b1; m_hs = 1'b1; m_bl = 1'b1;

        cycle(1'b1, 1'b1, 1'b1, 24'hFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_count", bus.oCOUNT, 0);
        check("rst_sync", {bus.oDISP_VSYNC, bus.oDISP_HSYNC, bus.oDISP_BLANK}, 3'b111);

        // three pixels in, three out, latency one
        op(1'b1, 24'h112233, 1'b0);
        op(1'b1, 24'h445566, 1'b0);
        op(1'b1, 24'h778899, 1'b0);
        check("tp1_cnt3", bus.oCOUNT, 3);
        op(1'b0, 24'h0, 1'b1);
        check("tp1_px0", {bus.oDISP_R, bus.oDISP_G, bus.oDISP_B}, 24'h112233);
        op(1'b0, 24'h0, 1'b1);
        check("tp1_px1", {bus.oDISP_R, bus.oDISP_G, bus.oDISP_B}, 24'h445566);
        op(1'b0, 24'h0, 1'b1);
        check("tp1_px2", {bus.oDISP_R, bus.oDISP_G, bus.oDISP_B}, 24'h778899);
        check("tp1_cnt0", bus.oCOUNT, 0);
        check("tp1_uf", bus.oUNDERFLOW, 0);

        // overfill, drain, refill across the pointer wrap
        for (int k = 0; k < 2; k++) begin
            for (int i = 1; i <= 70; i++) begin
                op(1'b1, 24'(i + k * 24'h100), 1'b0);
                if (i == 56) check("tp2_afull56", bus.oWR_ALMOST_FULL, 1);
                if (i == 55) check("tp2_afull55", bus.oWR_ALMOST_FULL, 0);
            end
            check("tp2_full", bus.oWR_FULL, 1);
            check("tp2_cnt", bus.oCOUNT, 64);
            for (int i = 1; i <= 64; i++) begin
                op(1'b0, 24'h0, 1'b1);
                if (i == 64) check("tp2_last", {bus.oDISP_R, bus.oDISP_G, bus.oDISP_B}, 24'(64 + k * 24'h100));
            end
        end

        // pop on empty with simultaneous write: stored, not forwarded
        op(1'b1, 24'hAABBCC, 1'b1);
        check("tp3_rgb0", {bus.oDISP_R, bus.oDISP_G, bus.oDISP_B}, 24'h0);
        check("tp3_uf", bus.oUNDERFLOW, 1);
        check("tp3_cnt", bus.oCOUNT, 1);
        op(1'b0, 24'h0, 1'b1);
        check("tp3_px", {bus.oDISP_R, bus.oDISP_G, bus.oDISP_B}, 24'hAABBCC);
        op(1'b0, 24'h0, 1'b0);
        check("tp3_uf_hold", bus.oUNDERFLOW, 1);
        cycle(1'b0, 1'b1, 1'b0, 24'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("tp3_uf_clr", bus.oUNDERFLOW, 0);

        // steady state at count 10
        for (int i = 0; i < 10; i++) op(1'b1, 24'($urandom), 1'b0);
        for (int i = 0; i < 20; i++) op(1'b1, 24'($urandom), 1'b1);
        check("tp4_cnt", bus.oCOUNT, 10);

        // flush swallows same-cycle write and pop; sync pipeline keeps running
        for (int i = 0; i < 10; i++) op(1'b1, 24'($urandom), 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 24'h123456, 1'b1, 1'b1, 1'b0, 1'b1);
        check("tp5_cnt", bus.oCOUNT, 0);
        check("tp5_hs", bus.oDISP_HSYNC, 0);
        cycle(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b1);

        // reset mid-line
        for (int i = 0; i < 5; i++) op(1'b1, 24'($urandom), 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 24'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("tp6_cnt", bus.oCOUNT, 0);
        op(1'b0, 24'h0, 1'b1);
        check("tp6_uf", bus.oUNDERFLOW, 1);

        // random traffic in phases of varying write/read pressure
        for (int ph = 0; ph < 12; ph++) begin
            int pw, pr;
            pw = $urandom_range(100, 10);
            pr = $urandom_range(100, 10);
            for (int i = 0; i < 150; i++) begin
                logic r, f;
                r = ($urandom_range(999, 0) < 3);
                f = ($urandom_range(999, 0) < 8);
                cycle(r, f, ($urandom_range(99, 0) < pw), 24'($urandom),
                      ($urandom_range(99, 0) < pr), 1'($urandom), 1'($urandom), 1'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_pixel_fifo_out.md
Name: vga_pixel_fifo_out

Overview:
Single-clock pixel FIFO sitting directly downstream of the 640x480@60Hz timing generator, in front of the ADV7123 DAC. The frame-buffer read engine pushes 24-bit RGB pixels; the timing generator's data-request pops one pixel per pixel clock. Timing syncs/blank are re-registered so they stay aligned with the registered RGB. Underflow is flagged as a sticky status bit.

Parameters:
P_DEPTH, 64, FIFO depth in pixels (power of two)
P_DEPTH_N, 6, log2(P_DEPTH); pointer width
P_AFULL, 56, oWR_ALMOST_FULL asserts when occupancy >= this value

Ports:
iVGA_CLOCK  in  1  pixel clock, 25.2MHz, all logic on rising edge
iRESET_SYNC  in  1  synchronous reset, active-high
iFLUSH  in  1  synchronous FIFO flush (driven at frame start)
iWR_REQ  in  1  upstream write strobe
iWR_DATA  in  24  pixel {R[23:16],G[15:8],B[7:0]}
oWR_FULL  out  1  occupancy == P_DEPTH
oWR_ALMOST_FULL  out  1  occupancy >= P_AFULL
oCOUNT  out  P_DEPTH_N+1  current occupancy
iDATA_REQ  in  1  pop request from timing generator
iDISP_VSYNC  in  1  vsync from timing generator
iDISP_HSYNC  in  1  hsync from timing generator
iDISP_BLANK  in  1  blank from timing generator
oDISP_R  out  8  red to DAC
oDISP_G  out  8  green to DAC
oDISP_B  out  8  blue to DAC
oDISP_VSYNC  out  1  vsync delayed 1 cycle
oDISP_HSYNC  out  1  hsync delayed 1 cycle
oDISP_BLANK  out  1  blank delayed 1 cycle
oUNDERFLOW  out  1  sticky: pop requested while empty

Behaviour:
- Reset (iRESET_SYNC=1 at edge): wr/rd pointers=0, count=0, oDISP_R/G/B=0, oDISP_VSYNC=1, oDISP_HSYNC=1, oDISP_BLANK=1, oUNDERFLOW=0. Reset overrides iFLUSH, writes, reads. Reset mid-line discards all stored pixels.
- Priority per cycle: reset > flush > normal read/write.
- Flush: pointers and count to 0, oUNDERFLOW cleared, RGB output forced 0 that cycle; iWR_REQ and iDATA_REQ in the flush cycle are ignored (no store, no underflow). Sync/blank pipeline keeps running during flush.
- Write accepted iff iWR_REQ=1 and count<P_DEPTH (evaluated on pre-cycle count). Write while full is dropped silently; no state change. A same-cycle pop does not make room for a write when full.
- Pop accepted iff iDATA_REQ=1 and count!=0 (pre-cycle count). Head pixel appears on oDISP_R/G/B the following cycle (latency 1), rd pointer increments.
- iDATA_REQ=1 with count==0: no pop, RGB<=0, oUNDERFLOW<=1 (held until flush/reset). No fall-through: a write into an empty FIFO in the same cycle is stored, not output.
- iDATA_REQ=0: RGB<=0 next cycle (black during blanking).
- Simultaneous accepted write and pop: count unchanged.
- Pointers wrap modulo P_DEPTH; count is P_DEPTH_N+1 bits, range 0..P_DEPTH.
- oDISP_VSYNC/HSYNC/BLANK = inputs registered once, so they align with RGB popped on the same request cycle.
- oWR_FULL, oWR_ALMOST_FULL, oCOUNT are combinational from registered count.
- Storage: inferred RAM or register array, P_DEPTH x 24; read data registered.

Test Plan:
- Reset then write 0x112233, 0x445566, 0x778899 on consecutive cycles, then iDATA_REQ=1 for 3 cycles -> RGB shows 11/22/33, 44/55/66, 77/88/99 one cycle after each request; oCOUNT 3->0; oUNDERFLOW=0.
- Write 70 pixels with no reads -> oWR_ALMOST_FULL rises when oCOUNT=56, oWR_FULL at 64; pixels 65-70 dropped; 64 pops return pixels 1-64 in order, pointer wrap verified by second fill.
- Empty FIFO, iDATA_REQ=1 with simultaneous write of 0xAABBCC -> RGB=0, oUNDERFLOW=1, oCOUNT=1; next pop returns AA/BB/CC; oUNDERFLOW stays 1 until iFLUSH.
- Count=10, simultaneous write+pop for 20 cycles -> oCOUNT stays 10, output order strictly FIFO.
- Count=20, assert iFLUSH together with iWR_REQ and iDATA_REQ -> next cycle oCOUNT=0, oUNDERFLOW=0, RGB=0; then drive iDISP_HSYNC pattern 0,1,1,0 -> oDISP_HSYNC shows same pattern one cycle later.
- Count=5 mid-line, assert iRESET_SYNC one cycle -> oCOUNT=0, RGB=0, oDISP_VSYNC/HSYNC/BLANK=1/1/1; subsequent pop flags underflow.
